fft_frame_ctrl: RTL and testbench
=================================

# fft_frame_ctrl

Frame scheduler for the 256-point FFT datapath. It decimates an incoming sample stream into a two-bank capture buffer, launches `fft_top` once a bank is full, and serves the FFT's input-RAM reads from that bank. When the FFT reports done, it latches the main/secondary peak bins into a result register. It sits between the ADC sample interface and `fft_top`, and the CPU-side register block reads its results.

## Interface
- `DATA_WIDTH`, 12, sample width, matches `fft_top` `INOUT_DATA_WIDTH`
- `ADDR_WIDTH`, 8, frame length 2^ADDR_WIDTH samples, bin index width
- `TIMEOUT`, 65535, max cycles from `fft_start` to `fft_done` before abort

- `clk` in 1: single clock for the whole block.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: level; capture runs while high.
- `single_shot` in 1: level, sampled at frame start; when high, stop after one completed frame.
- `decim` in 8: keep 1 of every `decim`+1 valid samples.
- `smp_valid` in 1: sample strobe.
- `smp_data` in DATA_WIDTH: signed sample.
- `fft_start` out 1: one-cycle launch pulse to `fft_top` `start`.
- `fft_ren` in 1: FFT input-RAM read enable.
- `fft_raddr` in ADDR_WIDTH: FFT input-RAM read address.
- `fft_rdata` out DATA_WIDTH: read data, registered.
- `fft_done` in 1: one-cycle completion pulse from `fft_top`.
- `peak1_bin` in ADDR_WIDTH: `ram_waddr_max1` from `fft_top`.
- `peak2_bin` in ADDR_WIDTH: `ram_waddr_max2` from `fft_top`.
- `res_valid` out 1: sticky; cleared by `res_ack`.
- `res_ack` in 1: one-cycle acknowledge.
- `res_bin1` out ADDR_WIDTH: latched main peak bin.
- `res_bin2` out ADDR_WIDTH: latched secondary peak bin.
- `frame_cnt` out 16: completed frames, wraps at 0xFFFF→0.
- `overrun` out 1: sticky; a kept sample was dropped.
- `timeout_err` out 1: sticky; FFT watchdog fired.
- `busy` out 1: FFT FSM not in F_IDLE.

## Operation
- Each bank has a state: EMPTY → FILLING → FULL → IN_FFT → EMPTY.
- Capture side:
  - Decimation counter counts `smp_valid` cycles while `enable` is high. A sample is kept when the counter equals `decim`; the counter then resets to 0.
  - A kept sample is written at write pointer `wp` into the FILLING bank.
  - At `wp` = 2^ADDR_WIDTH−1 the bank goes FULL, `wp` wraps to 0, and filling moves to the other bank if that bank is EMPTY.
  - If no bank is EMPTY, kept samples are dropped and `overrun` is set.
  - `enable` low: the decimation counter and `wp` hold, and the partial frame is kept.
- FFT FSM states:
  - F_IDLE: when any bank is FULL (lowest bank index first), go to F_START.
  - F_START: assert `fft_start` for 1 cycle, mark the bank IN_FFT, load the watchdog, go to F_BUSY.
  - F_BUSY: `fft_ren`/`fft_raddr` read from the IN_FFT bank. On `fft_done` go to F_REPORT. If the watchdog reaches 0, set `timeout_err`, free the bank and go to F_IDLE with no result.
  - F_REPORT (1 cycle, entered the cycle after `fft_done`): latch `peak1_bin`/`peak2_bin`, set `res_valid`, increment `frame_cnt`, free the bank, go to F_IDLE.
- If `res_valid` is already high at F_REPORT, the result is overwritten and `overrun` is set.
- `res_ack` and a same-cycle set of `res_valid`: the set wins.
- `single_shot`: after F_REPORT, capture is inhibited until `enable` falls and rises again.
- Bank select for FFT reads uses the IN_FFT bank, never the FILLING bank. A same-cycle write and read on different banks is legal.

## Timing
- `fft_rdata` is valid 1 cycle after `fft_ren`=1, and holds when `fft_ren`=0.
- `fft_start` rises 2 cycles after the write of the last sample of a frame: 1 cycle for the FULL update, 1 in F_START.
- Result latency: `res_valid` high 2 cycles after the `fft_done` pulse.
- Watchdog counts F_BUSY cycles; abort occurs on cycle TIMEOUT+1.
- Reset values:
  - All outputs 0: `fft_start`, `fft_rdata`, `res_valid`, `res_bin1`, `res_bin2`, `frame_cnt`, `overrun`, `timeout_err`, `busy`.
  - Banks EMPTY, bank 0 FILLING, `wp`=0, decimation counter 0, FSM F_IDLE.
- Reset mid-frame or mid-FFT discards all data. `fft_done` arriving in F_IDLE is ignored.

## Configuration
- `FFT_CTRL_PINGPONG_EN` defined: two banks, with capture overlapping FFT as above.
- Not defined:
  - Single bank; no capture while the bank is FULL or IN_FFT.
  - Kept samples arriving then are discarded silently; `overrun` is never set by capture.
  - Bank-1 storage is not instantiated.

## Test plan
- Decimation: `decim`=0 → all 256 samples are kept; `decim`=3 → 1024 `smp_valid` strobes fill the bank exactly. In both cases `fft_start` pulses once, 2 cycles after the 256th kept write.
- Readback: fill with ramp 0..255, drive `fft_raddr`=0x10 with `fft_ren` → `fft_rdata`=0x010 the next cycle; the value holds with `fft_ren`=0.
- Result: `fft_done` pulse with `peak1_bin`=0x21, `peak2_bin`=0x05 → after 2 cycles `res_valid`=1, `res_bin1`=0x21, `res_bin2`=0x05, `frame_cnt`=1; `res_ack` clears `res_valid`.
- Ping-pong/overrun with macro, continuous samples, `fft_done` withheld: bank 1 fills → `overrun`=1 on the next kept sample, with no second `fft_start` until `fft_done`. Without the macro, `overrun` stays 0.
- Watchdog: `TIMEOUT`=100, no `fft_done` → `timeout_err`=1 on F_BUSY cycle 101; `frame_cnt` unchanged; next full frame restarts.
- Async `rst` pulse in F_BUSY → all outputs 0 immediately; a following `fft_done` is ignored.

Source files
------------

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: decimating capture buffer, FFT launch/watchdog and
// peak-bin result register in front of fft_top.
// Optional feature macro: FFT_CTRL_PINGPONG_EN (two banks, capture overlaps
// the transform). Without it a single bank is built and capture pauses
// while that bank is full or being transformed.
module fft_frame_ctrl #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  single_shot,
  input  logic [7:0]            decim,
  input  logic                  smp_valid,
  input  logic [DATA_WIDTH-1:0] smp_data,
  output logic                  fft_start,
  input  logic                  fft_ren,
  input  logic [ADDR_WIDTH-1:0] fft_raddr,
  output logic [DATA_WIDTH-1:0] fft_rdata,
  input  logic                  fft_done,
  input  logic [ADDR_WIDTH-1:0] peak1_bin,
  input  logic [ADDR_WIDTH-1:0] peak2_bin,
  output logic                  res_valid,
  input  logic                  res_ack,
  output logic [ADDR_WIDTH-1:0] res_bin1,
  output logic [ADDR_WIDTH-1:0] res_bin2,
  output logic [15:0]           frame_cnt,
  output logic                  overrun,
  output logic                  timeout_err,
  output logic                  busy
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
`ifdef FFT_CTRL_PINGPONG_EN
  localparam int unsigned NBANK = 2;
`else
  localparam int unsigned NBANK = 1;
`endif

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_IN_FFT} bank_st_t;
  typedef enum logic [1:0] {F_IDLE, F_START, F_BUSY, F_REPORT} fsm_t;

  bank_st_t              bank_q [2];
  bank_st_t              bank_d [2];
  logic                  fill_q, fill_d;
  logic [ADDR_WIDTH-1:0] wp_q, wp_d;
  logic [7:0]            dcnt_q, dcnt_d;
  logic                  keep, wr_en, drop_ovr, have_fill;
  fsm_t                  state_q, state_d;
  logic                  cur_q, cur_d;
  logic                  start_c, free_c, report_c, tmo_c;
  logic [WD_W-1:0]       wd_q;
  logic                  inhibit_q, ss_frame_q;

  logic [DATA_WIDTH-1:0] mem0 [DEPTH];
`ifdef FFT_CTRL_PINGPONG_EN
  logic [DATA_WIDTH-1:0] mem1 [DEPTH];
`endif

  // Capture side: decimation, write pointer and bank state transitions
  always_comb begin
    bank_d    = bank_q;
    fill_d    = fill_q;
    wp_d      = wp_q;
    dcnt_d    = dcnt_q;
    keep      = 1'b0;
    wr_en     = 1'b0;
    drop_ovr  = 1'b0;
    have_fill = 1'b0;
    if (enable && smp_valid && !inhibit_q) begin
      if (dcnt_q == decim) begin
        keep   = 1'b1;
        dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + 8'd1;
      end
    end
    if (keep) begin
      if (bank_q[fill_q] == B_FILLING) begin
        wr_en = 1'b1;
        if (&wp_q) begin
          bank_d[fill_q] = B_FULL;
          wp_d           = '0;
        end else begin
          wp_d = wp_q + ADDR_WIDTH'(1);
        end
      end else begin
        drop_ovr = (NBANK > 1);
      end
    end
    if (start_c) bank_d[cur_q] = B_IN_FFT;
    if (free_c)  bank_d[cur_q] = B_EMPTY;
    // keep exactly one bank filling whenever an empty one exists
    for (int unsigned b = 0; b < NBANK; b++)
      if (bank_d[1'(b)] == B_FILLING) have_fill = 1'b1;
    for (int unsigned b = 0; b < NBANK; b++) begin
      if (!have_fill && bank_d[1'(b)] == B_EMPTY) begin
        bank_d[1'(b)] = B_FILLING;
        fill_d        = 1'(b);
        have_fill     = 1'b1;
      end
    end
  end

  // FFT FSM next-state and control strobes
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    start_c  = 1'b0;
    free_c   = 1'b0;
    report_c = 1'b0;
    tmo_c    = 1'b0;
    case (state_q)
      F_IDLE: begin
        if (bank_q[0] == B_FULL) begin
          cur_d   = 1'b0;
          state_d = F_START;
        end else if (NBANK > 1 && bank_q[1] == B_FULL) begin
          cur_d   = 1'b1;
          state_d = F_START;
        end
      end
      F_START: begin
        start_c = 1'b1;
        state_d = F_BUSY;
      end
      F_BUSY: begin
        if (fft_done) begin
          state_d = F_REPORT;
        end else if (wd_q == '0) begin
          tmo_c   = 1'b1;
          free_c  = 1'b1;
          state_d = F_IDLE;
        end
      end
      F_REPORT: begin
        report_c = 1'b1;
        free_c   = 1'b1;
        state_d  = F_IDLE;
      end
      default: state_d = F_IDLE;
    endcase
  end

  // State, bank bookkeeping, watchdog and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= F_IDLE;
      cur_q       <= 1'b0;
      bank_q[0]   <= B_FILLING;
      bank_q[1]   <= B_EMPTY;
      fill_q      <= 1'b0;
      wp_q        <= '0;
      dcnt_q      <= '0;
      wd_q        <= '0;
      inhibit_q   <= 1'b0;
      ss_frame_q  <= 1'b0;
      fft_start   <= 1'b0;
      fft_rdata   <= '0;
      res_valid   <= 1'b0;
      res_bin1    <= '0;
      res_bin2    <= '0;
      frame_cnt   <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      bank_q    <= bank_d;
      fill_q    <= fill_d;
      wp_q      <= wp_d;
      dcnt_q    <= dcnt_d;
      fft_start <= start_c;
      busy      <= (state_d != F_IDLE);
      if (start_c)
        wd_q <= WD_W'(TIMEOUT);
      else if (state_q == F_BUSY && wd_q != '0)
        wd_q <= wd_q - WD_W'(1);
      if (wr_en && wp_q == '0) ss_frame_q <= single_shot;
      if (report_c && ss_frame_q)
        inhibit_q <= 1'b1;
      else if (!enable)
        inhibit_q <= 1'b0;
      if (fft_ren) begin
`ifdef FFT_CTRL_PINGPONG_EN
        fft_rdata <= cur_q ? mem1[fft_raddr] : mem0[fft_raddr];
`else
        fft_rdata <= mem0[fft_raddr];
`endif
      end
      if (report_c) begin
        res_bin1  <= peak1_bin;
        res_bin2  <= peak2_bin;
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (report_c)
        res_valid <= 1'b1;
      else if (res_ack)
        res_valid <= 1'b0;
      if ((report_c && res_valid) || drop_ovr) overrun <= 1'b1;
      if (tmo_c) timeout_err <= 1'b1;
    end
  end

  // Sample storage (no reset: contents are only meaningful once written)
  always_ff @(posedge clk) begin
`ifdef FFT_CTRL_PINGPONG_EN
    if (wr_en && fill_q)  mem1[wp_q] <= smp_data;
    if (wr_en && !fill_q) mem0[wp_q] <= smp_data;
`else
    if (wr_en) mem0[wp_q] <= smp_data;
`endif
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl; works with or without
// FFT_CTRL_PINGPONG_EN defined.
module tb_fft_frame_ctrl;
  localparam int unsigned DW  = 12;
  localparam int unsigned AW  = 8;
  localparam int unsigned TMO = 300;
`ifdef FFT_CTRL_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] b1;
    logic [AW-1:0] b2;
    logic [15:0]   fc;
  } res_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          single_shot = 1'b0;
  logic [7:0]    decim = 8'd0;
  logic          smp_valid = 1'b0;
  logic [DW-1:0] smp_data = '0;
  logic          fft_start;
  logic          fft_ren = 1'b0;
  logic [AW-1:0] fft_raddr = '0;
  logic [DW-1:0] fft_rdata;
  logic          fft_done = 1'b0;
  logic [AW-1:0] peak1_bin = '0;
  logic [AW-1:0] peak2_bin = '0;
  logic          res_valid;
  logic          res_ack = 1'b0;
  logic [AW-1:0] res_bin1;
  logic [AW-1:0] res_bin2;
  logic [15:0]   frame_cnt;
  logic          overrun;
  logic          timeout_err;
  logic          busy;

  int            n_vec = 0;
  int            n_err = 0;
  int            n_start = 0;
  logic [15:0]   exp_fc = '0;
  logic [DW-1:0] rd_q [$];
  res_t          res_q [$];

  fft_frame_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .single_shot(single_shot),
    .decim(decim), .smp_valid(smp_valid), .smp_data(smp_data),
    .fft_start(fft_start), .fft_ren(fft_ren), .fft_raddr(fft_raddr),
    .fft_rdata(fft_rdata), .fft_done(fft_done), .peak1_bin(peak1_bin),
    .peak2_bin(peak2_bin), .res_valid(res_valid), .res_ack(res_ack),
    .res_bin1(res_bin1), .res_bin2(res_bin2), .frame_cnt(frame_cnt),
    .overrun(overrun), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance to the next falling edge, noting launch pulses seen there
  task automatic step();
    @(negedge clk);
    if (fft_start) n_start++;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_start"}, 32'(fft_start), 32'd0);
    check({tag, "_rdata"}, 32'(fft_rdata), 32'd0);
    check({tag, "_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_bin1"},  32'(res_bin1),  32'd0);
    check({tag, "_bin2"},  32'(res_bin2),  32'd0);
    check({tag, "_fcnt"},  32'(frame_cnt), 32'd0);
    check({tag, "_ovr"},   32'(overrun),   32'd0);
    check({tag, "_tmo"},   32'(timeout_err), 32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
  endtask

  task automatic feed(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      smp_valid = 1'b1;
      smp_data  = DW'(base + i);
      step();
    end
    smp_valid = 1'b0;
  endtask

  // launch must appear exp_lat falling edges after the last write edge
  task automatic wait_start(input int exp_lat);
    int  cnt = 0;
    bit  seen = 1'b0;
    while (!seen && cnt < 20) begin
      step();
      cnt++;
      seen = fft_start;
    end
    check("start_latency", seen ? 32'(cnt) : 32'hFFFF_FFFF, 32'(exp_lat));
    step();
    check("start_pulse_width", 32'(fft_start), 32'd0);
  endtask

  task automatic rd(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    fft_ren   = 1'b1;
    fft_raddr = addr;
    rd_q.push_back(exp);
    step();
    fft_ren   = 1'b0;
    fft_raddr = ~addr;
    check("rdata", 32'(fft_rdata), 32'(rd_q.pop_front()));
    step();
    check("rdata_hold", 32'(fft_rdata), 32'(exp));
  endtask

  task automatic deliver(input logic [AW-1:0] b1, input logic [AW-1:0] b2, input bit valid_before);
    res_t r;
    fft_done  = 1'b1;
    peak1_bin = b1;
    peak2_bin = b2;
    exp_fc    = exp_fc + 16'd1;
    res_q.push_back('{b1, b2, exp_fc});
    step();
    fft_done = 1'b0;
    check("res_valid_early", 32'(res_valid), 32'(valid_before));
    step();
    peak1_bin = '0;
    peak2_bin = '0;
    r = res_q.pop_front();
    check("res_valid", 32'(res_valid), 32'd1);
    check("res_bin1", 32'(res_bin1), 32'(r.b1));
    check("res_bin2", 32'(res_bin2), 32'(r.b2));
    check("frame_cnt", 32'(frame_cnt), 32'(r.fc));
  endtask

  task automatic ack();
    res_ack = 1'b1;
    step();
    res_ack = 1'b0;
    check("res_ack_clear", 32'(res_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1);
  end

  initial begin
    int  base;
    bit  seen;
    // reset values
    step();
    step();
    check_zero("reset");
    rst = 1'b0;
    enable = 1'b1;
    step();

    // decim 0: 256 kept ramp samples, readback, result, ack
    base = n_start;
    decim = 8'd0;
    feed(256, 0);
    check("no_early_start", 32'(n_start - base), 32'd0);
    wait_start(2);
    check("one_start", 32'(n_start - base), 32'd1);
    check("busy", 32'(busy), 32'd1);
    rd(8'h10, 12'h010);
    rd(8'h00, 12'h000);
    rd(8'hFF, 12'h0FF);
    deliver(8'h21, 8'h05, 1'b0);
    step();
    check("idle_after_report", 32'(busy), 32'd0);
    ack();

    // decim 3: 1024 strobes fill exactly one frame of every 4th value
    base = n_start;
    decim = 8'd3;
    feed(1024, 0);
    check("decim3_no_early_start", 32'(n_start - base), 32'd0);
    wait_start(2);
    check("decim3_one_start", 32'(n_start - base), 32'd1);
    rd(8'h10, 12'd67);
    rd(8'hFF, 12'd1023);
    deliver(8'h7A, 8'hC3, 1'b0);

    // unacknowledged result overwritten by the next frame
    decim = 8'd0;
    feed(256, 500);
    wait_start(2);
    rd(8'h02, 12'd502);
    check("ovr_before_overwrite", 32'(overrun), 32'd0);
    deliver(8'h11, 8'h22, 1'b1);
    check("ovr_overwrite", 32'(overrun), 32'd1);
    ack();

    // watchdog: no fft_done; F_BUSY cycle 2 at this point
    feed(256, 0);
    wait_start(2);
    for (int k = 3; k <= int'(TMO) + 2; k++) begin
      step();
      if (k == int'(TMO)) begin
        check("tmo_not_yet", 32'(timeout_err), 32'd0);
        check("tmo_busy_before", 32'(busy), 32'd1);
      end
    end
    check("timeout_err", 32'(timeout_err), 32'd1);
    check("tmo_busy_after", 32'(busy), 32'd0);
    check("tmo_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
    // stray done in idle is ignored
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    step();
    step();
    check("stray_done_valid", 32'(res_valid), 32'd0);
    check("stray_done_fcnt", 32'(frame_cnt), 32'(exp_fc));
    // next frame restarts normally
    feed(256, 0);
    wait_start(2);
    deliver(8'h40, 8'h41, 1'b0);

    // async reset while the FFT is running
    feed(256, 100);
    wait_start(2);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    exp_fc = '0;
    rd_q.delete();
    res_q.delete();
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    step();
    step();
    check("post_rst_valid", 32'(res_valid), 32'd0);
    check("post_rst_fcnt", 32'(frame_cnt), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    // continuous capture with fft_done withheld
    base = n_start;
    feed(512, 0);
    check("cont_one_start", 32'(n_start - base), 32'd1);
    check("cont_ovr_before", 32'(overrun), 32'd0);
    feed(1, 0);
    check("cont_ovr_after", 32'(overrun), 32'(PP));
    check("cont_no_second_start", 32'(n_start - base), 32'd1);
    deliver(8'h33, 8'h44, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = fft_start;
    end
    check("second_start_after_done", 32'(seen), 32'(PP));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
